// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch controller: FSM states, FIFO entry layout
// and small helpers used by the controller and its fetch buffer.
package ifetch_pkg;

   localparam int XLEN_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DROP = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [XLEN_DEF-1:0] instr;
   } fetch_entry_t;

   // True when a fetch address is not word aligned.
   function automatic logic pc_misaligned(input logic [1:0] pc_low);
      return (pc_low != 2'b00);
   endfunction

endpackage

// File: rtl/ifetch_ctrl_fifo.sv
// Fetch buffer: synchronous FIFO of {pc,instr} entries with a registered head,
// so the decode-side outputs come straight from flops. Flush empties it at once.
module fetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  fetch_entry_t               din,
   input  logic                       pop,
   output fetch_entry_t               head,
   output logic                       head_valid,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t    mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   fetch_entry_t    head_r;
   logic            head_valid_r;

   logic            do_push_s;
   logic            do_pop_s;
   logic [AW-1:0]   rd_ptr_next_s;
   logic [CW-1:0]   remain_s;
   logic [CW-1:0]   count_next_s;
   fetch_entry_t    head_next_s;
   logic            head_valid_next_s;

   // Qualify push/pop and work out which entry becomes the head after this cycle.
   always_comb begin
      do_pop_s          = pop && (count_r != {CW{1'b0}});
      do_push_s         = push && ((count_r != CW'(DEPTH)) || do_pop_s);
      rd_ptr_next_s     = rd_ptr_r + AW'(do_pop_s);
      remain_s          = count_r - CW'(do_pop_s);
      count_next_s      = remain_s + CW'(do_push_s);
      head_next_s       = '0;
      head_valid_next_s = 1'b0;
      if (flush) begin
         head_next_s       = '0;
         head_valid_next_s = 1'b0;
      end else if (remain_s == {CW{1'b0}}) begin
         // Buffer drains this cycle: a pushed entry goes straight to the head.
         head_next_s       = do_push_s ? din : '0;
         head_valid_next_s = do_push_s;
      end else begin
         head_next_s       = mem_r[rd_ptr_next_s];
         head_valid_next_s = 1'b1;
      end
   end

   // Storage, pointers, occupancy and registered head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         count_r      <= '0;
         head_r       <= '0;
         head_valid_r <= 1'b0;
      end else if (flush) begin
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         count_r      <= '0;
         head_r       <= '0;
         head_valid_r <= 1'b0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
         end
         wr_ptr_r     <= wr_ptr_r + AW'(do_push_s);
         rd_ptr_r     <= rd_ptr_next_s;
         count_r      <= count_next_s;
         head_r       <= head_next_s;
         head_valid_r <= head_valid_next_s;
      end
   end

   assign head       = head_r;
   assign head_valid = head_valid_r;
   assign count      = count_r;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: issues one memory request at a time for the current
// PC, buffers responses for decode and stalls the PC stage until a request is granted.
module ifetch_ctrl
   import ifetch_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int FIFO_DEPTH = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_redirect,
   output logic            o_pc_stall,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [XLEN-1:0] i_imem_rdata,
   output logic            o_instr_valid,
   output logic [XLEN-1:0] o_instr,
   output logic [XLEN-1:0] o_instr_pc,
   input  logic            i_instr_ready,
   output logic            o_misalign
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int OW = CW + 1;
   localparam logic [OW-1:0] DEPTH_W = OW'(FIFO_DEPTH);

   fetch_state_e    state_r;
   fetch_state_e    state_next_s;
   logic            outstanding_r;
   logic [XLEN-1:0] req_pc_r;
   logic            misalign_r;

   logic [CW-1:0]   fifo_count_s;
   fetch_entry_t    head_s;
   fetch_entry_t    push_data_s;
   logic            head_valid_s;
   logic            push_s;
   logic            pop_s;
   logic            req_s;
   logic            grant_s;
   logic [OW-1:0]   occupancy_s;
   logic [OW-1:0]   after_push_s;
   logic            room_idle_s;
   logic            room_after_s;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (i_clk),
      .rst_n      (i_rst),
      .flush      (i_redirect),
      .push       (push_s),
      .din        (push_data_s),
      .pop        (pop_s),
      .head       (head_s),
      .head_valid (head_valid_s),
      .count      (fifo_count_s)
   );

   // Buffer handshakes and space accounting; a slot is reserved for every issued request.
   always_comb begin
      pop_s             = head_valid_s && i_instr_ready && !i_redirect;
      push_s            = (state_r == WAIT) && i_imem_rvalid && !i_redirect;
      push_data_s.pc    = req_pc_r;
      push_data_s.instr = i_imem_rdata;
      occupancy_s       = {1'b0, fifo_count_s} + OW'(outstanding_r);
      after_push_s      = {1'b0, fifo_count_s} + OW'(1'b1) - OW'(pop_s);
      room_idle_s       = (occupancy_s < DEPTH_W);
      room_after_s      = (after_push_s < DEPTH_W);
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic; redirect takes priority over every handshake.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (!i_redirect && room_idle_s) begin
               state_next_s = REQ;
            end else begin
               state_next_s = IDLE;
            end
         end
         REQ: begin
            if (i_redirect) begin
               state_next_s = IDLE;
            end else if (i_imem_gnt) begin
               state_next_s = WAIT;
            end else begin
               state_next_s = REQ;
            end
         end
         WAIT: begin
            if (i_redirect) begin
               // A response arriving with the redirect is consumed here, so nothing is left to drop.
               state_next_s = i_imem_rvalid ? IDLE : DROP;
            end else if (i_imem_rvalid) begin
               if (grant_s) begin
                  state_next_s = WAIT;
               end else if (room_after_s) begin
                  state_next_s = REQ;
               end else begin
                  state_next_s = IDLE;
               end
            end else begin
               state_next_s = WAIT;
            end
         end
         DROP: begin
            // Only one request is ever in flight, so any response ends the drop.
            if (i_imem_rvalid) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DROP;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // FSM outputs: request in REQ, or back-to-back re-issue in the response cycle of WAIT.
   always_comb begin
      req_s = 1'b0;
      case (state_r)
         REQ: begin
            req_s = !i_redirect;
         end
         WAIT: begin
            req_s = !i_redirect && i_imem_rvalid && room_after_s;
         end
         default: begin
            req_s = 1'b0;
         end
      endcase
      grant_s = req_s && i_imem_gnt;
   end

   // Outstanding-request tracking, request PC capture and sticky misalignment flag.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         outstanding_r <= 1'b0;
         req_pc_r      <= '0;
         misalign_r    <= 1'b0;
      end else begin
         if (grant_s) begin
            outstanding_r <= 1'b1;
            req_pc_r      <= i_pc;
         end else if (i_imem_rvalid) begin
            outstanding_r <= 1'b0;
         end else begin
            outstanding_r <= outstanding_r;
         end
         if (req_s && pc_misaligned(i_pc[1:0])) begin
            misalign_r <= 1'b1;
         end else begin
            misalign_r <= misalign_r;
         end
      end
   end

   assign o_imem_req    = req_s;
   assign o_imem_addr   = i_pc;
   assign o_pc_stall    = !grant_s;
   assign o_instr_valid = head_valid_s;
   assign o_instr       = head_s.instr;
   assign o_instr_pc    = head_s.pc;
   assign o_misalign    = misalign_r;

endmodule
